// File: rtl/cw_bus_master.sv
// cw_bus_master: Wishbone slave bridged onto a narrow CW master bus.
// Sends a header frame, then write beats or turnaround plus read beats.
module cw_bus_master #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 16,
   parameter int SEL_W   = 2,
   parameter int CW_W    = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_adr,
   input  logic [DATA_W-1:0] wb_o_dat,
   input  logic [SEL_W-1:0]  wb_sel,
   input  logic              wb_4_burst,
   input  logic              wb_8_burst,
   output logic [DATA_W-1:0] wb_i_dat,
   output logic              wb_ack,
   output logic              wb_err,
   output logic [CW_W-1:0]   cw_io_o,
   input  logic [CW_W-1:0]   cw_io_i,
   output logic              cw_req,
   output logic              cw_dir,
   input  logic              cw_ack,
   input  logic              cw_err
);

   localparam int HDR_W = 3 + SEL_W + ADDR_W;
   localparam int HB    = (HDR_W + CW_W - 1) / CW_W;
   localparam int DB    = (DATA_W + CW_W - 1) / CW_W;
   localparam int HB_W  = HB * CW_W;
   localparam int DB_W  = DB * CW_W;
   localparam int SH_W  = (HB_W > DB_W) ? HB_W : DB_W;
   localparam int NB    = (HB > DB) ? HB : DB;
   localparam int CNT_W = $clog2(NB + 1);
   localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_WDATA, S_WACK, S_TURN, S_RDATA, S_END
   } state_t;

   state_t            r_st;
   logic [SH_W-1:0]   r_sh;
   logic [DB_W-1:0]   r_asm;
   logic [DATA_W-1:0] r_rdat;
   logic [CNT_W-1:0]  r_cnt;
   logic [TW-1:0]     r_wait;
   logic [2:0]        r_left;
   logic              r_we;
   logic              r_pend;
   logic              r_req;
   logic              r_dir;
   logic              r_ack;
   logic              r_err;

   logic [1:0]        w_burst;
   logic [SH_W-1:0]   w_hdr;
   logic [SH_W-1:0]   w_dat;
   logic [DB_W-1:0]   w_in;
   logic [DB_W-1:0]   w_asm;
   logic              w_to;
   logic              w_fail;
   logic              w_hlast;
   logic              w_dlast;
   logic [CW_W-1:0]   w_io;

   assign w_burst = wb_8_burst ? 2'b10 : (wb_4_burst ? 2'b01 : 2'b00);
   assign w_hdr   = SH_W'({wb_we, w_burst, wb_sel, wb_adr});
   assign w_dat   = SH_W'(wb_o_dat);
   // Read beats enter at the top so the first (LSB) beat ends at bit 0.
   assign w_in    = DB_W'(cw_io_i) << (DB_W - CW_W);
   assign w_asm   = (r_asm >> CW_W) | w_in;
   assign w_to    = (TIMEOUT > 0) && (r_wait == TW'(TLIM));
   assign w_fail  = cw_err | (w_to & ~cw_ack);
   assign w_hlast = (r_cnt == CNT_W'(HB - 1));
   assign w_dlast = (r_cnt == CNT_W'(DB - 1));

   // First write beat comes straight from the bus so it is sampled as issued.
   always_comb begin
      w_io = '0;
      if (r_st == S_HDR) begin
         w_io = r_sh[CW_W-1:0];
      end else if (r_st == S_WDATA) begin
         if (r_cnt == '0) w_io = wb_o_dat[CW_W-1:0];
         else             w_io = r_sh[CW_W-1:0];
      end
   end

   assign cw_io_o  = w_io;
   assign cw_req   = r_req;
   assign cw_dir   = r_dir;
   assign wb_i_dat = r_rdat;
   assign wb_ack   = r_ack & wb_cyc;
   assign wb_err   = r_err & wb_cyc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_st   <= S_IDLE;
         r_sh   <= '0;
         r_asm  <= '0;
         r_rdat <= '0;
         r_cnt  <= '0;
         r_wait <= '0;
         r_left <= '0;
         r_we   <= 1'b0;
         r_pend <= 1'b0;
         r_req  <= 1'b0;
         r_dir  <= 1'b0;
         r_ack  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         if (r_st != S_IDLE && r_st != S_END && !wb_cyc) begin
            r_st   <= S_END;
            r_req  <= 1'b0;
            r_dir  <= 1'b0;
            r_pend <= 1'b0;
         end else begin
            unique case (r_st)
               S_IDLE: begin
                  if (wb_cyc && wb_stb) begin
                     r_st   <= S_HDR;
                     r_req  <= 1'b1;
                     r_dir  <= 1'b0;
                     r_sh   <= w_hdr;
                     r_cnt  <= '0;
                     r_we   <= wb_we;
                     r_pend <= 1'b0;
                     r_left <= wb_8_burst ? 3'd7 :
                               (wb_4_burst ? 3'd3 : 3'd0);
                  end
               end
               S_HDR: begin
                  r_sh <= r_sh >> CW_W;
                  if (w_hlast) begin
                     r_cnt <= '0;
                     if (r_we) begin
                        r_st <= S_WDATA;
                     end else begin
                        r_st  <= S_TURN;
                        r_dir <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_WDATA: begin
                  if (r_cnt == '0) r_sh <= w_dat >> CW_W;
                  else             r_sh <= r_sh >> CW_W;
                  if (w_dlast) begin
                     r_cnt  <= '0;
                     r_wait <= '0;
                     r_st   <= S_WACK;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_WACK: begin
                  if (r_pend) begin
                     // wb_ack is visible now; next word is on the bus after it.
                     r_pend <= 1'b0;
                     r_cnt  <= '0;
                     r_st   <= S_WDATA;
                  end else if (w_fail) begin
                     r_err <= 1'b1;
                     r_st  <= S_END;
                     r_req <= 1'b0;
                     r_dir <= 1'b0;
                  end else if (cw_ack) begin
                     r_ack  <= 1'b1;
                     r_wait <= '0;
                     if (r_left == 3'd0) begin
                        r_st  <= S_END;
                        r_req <= 1'b0;
                        r_dir <= 1'b0;
                     end else begin
                        r_left <= r_left - 3'd1;
                        r_pend <= 1'b1;
                     end
                  end else begin
                     r_wait <= r_wait + TW'(1);
                  end
               end
               S_TURN: begin
                  r_st   <= S_RDATA;
                  r_cnt  <= '0;
                  r_wait <= '0;
               end
               S_RDATA: begin
                  if (w_fail) begin
                     r_err <= 1'b1;
                     r_st  <= S_END;
                     r_req <= 1'b0;
                     r_dir <= 1'b0;
                  end else if (cw_ack) begin
                     r_wait <= '0;
                     r_asm  <= w_asm;
                     if (w_dlast) begin
                        r_cnt  <= '0;
                        r_ack  <= 1'b1;
                        r_rdat <= w_asm[DATA_W-1:0];
                        if (r_left == 3'd0) begin
                           r_st  <= S_END;
                           r_req <= 1'b0;
                           r_dir <= 1'b0;
                        end else begin
                           r_left <= r_left - 3'd1;
                        end
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end else begin
                     r_wait <= r_wait + TW'(1);
                  end
               end
               S_END: begin
                  r_st <= S_IDLE;
               end
               default: begin
                  r_st <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cw_bus_master.sv
// tb_cw_bus_master: random Wishbone/CW transactions against a frame model,
// plus narrow-bus, timeout, abort and reset cases on a second instance.
module tb_cw_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cyc, stb, we, b4, b8, cack, cerr;
   logic [23:0] adr;
   logic [15:0] odat, io_i;
   logic [1:0]  sel;

   logic [15:0] a_idat, a_io, b_idat;
   logic [7:0]  b_io;
   logic        a_ack, a_err, a_req, a_dir;
   logic        b_ack, b_err, b_req, b_dir;

   int n_chk = 0;
   int n_err = 0;

   cw_bus_master u_a (
      .i_clk(clk), .i_rst(rst),
      .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
      .wb_adr(adr), .wb_o_dat(odat), .wb_sel(sel),
      .wb_4_burst(b4), .wb_8_burst(b8),
      .wb_i_dat(a_idat), .wb_ack(a_ack), .wb_err(a_err),
      .cw_io_o(a_io), .cw_io_i(io_i),
      .cw_req(a_req), .cw_dir(a_dir),
      .cw_ack(cack), .cw_err(cerr)
   );

   cw_bus_master #(.CW_W(8), .TIMEOUT(8)) u_b (
      .i_clk(clk), .i_rst(rst),
      .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
      .wb_adr(adr), .wb_o_dat(odat), .wb_sel(sel),
      .wb_4_burst(b4), .wb_8_burst(b8),
      .wb_i_dat(b_idat), .wb_ack(b_ack), .wb_err(b_err),
      .cw_io_o(b_io), .cw_io_i(io_i[7:0]),
      .cw_req(b_req), .cw_dir(b_dir),
      .cw_ack(cack), .cw_err(cerr)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One Wishbone request on u_a; the bench plays both master and CW slave.
   task automatic txn(input bit w, input bit [1:0] bc, input int ew,
                      input int maxw, input logic [23:0] a,
                      input logic [1:0] s, input int mode);
      int          n;
      logic [31:0] h;
      logic [15:0] wd[8];
      n = (bc == 2'd2) ? 8 : ((bc == 2'd1) ? 4 : 1);
      for (int i = 0; i < 8; i++) begin
         if (mode == 2) wd[i] = 16'(i + 1) * 16'h1111;
         else           wd[i] = 16'($urandom);
      end
      if (mode == 1) wd[0] = 16'hBEEF;
      h = 32'(w) * 32'h1000_0000 + 32'(bc) * 32'h0400_0000
        + 32'(s) * 32'h0100_0000 + 32'(a);
      adr  = a;
      sel  = s;
      we   = w;
      b8   = (bc == 2'd2);
      b4   = (bc == 2'd1) || (bc == 2'd2 && $urandom_range(0, 1) == 1);
      odat = wd[0];
      cyc  = 1'b1;
      stb  = 1'b1;
      step();
      check("req", 32'(a_req), 1);
      check("hdr0", 32'(a_io), h % 32'h10000);
      step();
      check("hdr1", 32'(a_io), h / 32'h10000);
      check("hdr_dir", 32'(a_dir), 0);
      step();
      if (!w) begin
         check("turn", 32'({a_dir, a_io}), 32'h10000);
         step();
      end
      for (int i = 0; i < n; i++) begin
         if (w) begin
            check("wdat", 32'(a_io), 32'(wd[i]));
            check("wdir", 32'(a_dir), 0);
            step();
         end
         repeat ($urandom_range(0, maxw)) begin
            check("wait", 32'({a_ack, a_err}), 0);
            step();
         end
         if (i == ew) begin
            cerr = 1'b1;
            cack = 1'($urandom_range(0, 1));
         end else begin
            cack = 1'b1;
         end
         if (!w) io_i = wd[i];
         step();
         cack = 1'b0;
         cerr = 1'b0;
         io_i = 16'($urandom);
         if (i == ew) begin
            check("err", 32'({a_ack, a_err}), 1);
            check("err_end", 32'({a_req, a_dir}), 0);
            break;
         end
         check("ack", 32'({a_ack, a_err}), 2);
         if (!w) check("rdat", 32'(a_idat), 32'(wd[i]));
         if (i == n - 1) begin
            check("end", 32'({a_req, a_dir}), 0);
         end else begin
            if (w) odat = wd[i + 1];
            step();
         end
      end
      cyc = 1'b0;
      stb = 1'b0;
      step();
      check("idle", 32'({a_req, a_ack, a_err}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bit          rw;
      bit [1:0]    rbc;
      int          rn, rew, t;
      logic        seen;
      logic [31:0] h;

      rst  = 1'b1;
      cyc  = 1'b0; stb = 1'b0; we = 1'b0;
      b4   = 1'b0; b8  = 1'b0;
      adr  = '0;   odat = '0; sel = '0;
      io_i = '0;   cack = 1'b0; cerr = 1'b0;
      step();
      step();
      check("rst_a", 32'({a_req, a_dir, a_ack, a_err, a_io}), 0);
      check("rst_a_dat", 32'(a_idat), 0);
      check("rst_b", 32'({b_req, b_dir, b_ack, b_err, b_io, b_idat}), 0);
      rst = 1'b0;
      step();

      txn(1'b1, 2'd0, -1, 0, 24'h001234, 2'b11, 1);
      txn(1'b0, 2'd1, -1, 2, 24'h000100, 2'b11, 2);
      txn(1'b0, 2'd2, 3, 2, 24'($urandom), 2'($urandom), 0);

      for (int k = 0; k < 40; k++) begin
         rw  = 1'($urandom);
         rbc = 2'($urandom_range(0, 2));
         rn  = (rbc == 2'd2) ? 8 : ((rbc == 2'd1) ? 4 : 1);
         rew = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
         txn(rw, rbc, rew, $urandom_range(0, 3),
             24'($urandom), 2'($urandom), 0);
      end

      // Master drops wb_cyc while waiting for the slave ack.
      we = 1'b1; b4 = 1'b0; b8 = 1'b0; odat = 16'h1357;
      cyc = 1'b1; stb = 1'b1;
      repeat (5) step();
      cyc = 1'b0; stb = 1'b0; cack = 1'b1;
      step();
      cack = 1'b0;
      check("abort", 32'({a_req, a_dir, a_ack, a_err}), 0);
      step();
      check("abort_idle", 32'({a_req, a_ack, a_err}), 0);

      // Reset in the middle of a header.
      we = 1'b0; b8 = 1'b1; cyc = 1'b1; stb = 1'b1;
      step();
      check("mid_req", 32'(a_req), 1);
      rst = 1'b1;
      step();
      check("rst_mid", 32'({a_req, a_dir, a_ack, a_err, a_io}), 0);
      check("rst_mid_dat", 32'(a_idat), 0);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; b8 = 1'b0;
      step();

      // Narrow bus read on u_b.
      rst = 1'b1; step(); rst = 1'b0; step();
      we = 1'b0; adr = 24'h000100; sel = 2'b11;
      cyc = 1'b1; stb = 1'b1;
      step();
      h = 32'h0300_0100;
      for (int k = 0; k < 4; k++) begin
         check("b_hdr", 32'(b_io), (h >> (8 * k)) % 32'h100);
         step();
      end
      check("b_turn", 32'({b_dir, b_io}), 32'h100);
      step();
      cack = 1'b1; io_i = 16'h00CD;
      step();
      io_i = 16'h00AB;
      check("b_mid", 32'({b_ack, b_err}), 0);
      step();
      cack = 1'b0;
      check("b_rd", 32'({b_ack, b_idat}), 32'h1ABCD);
      check("b_end", 32'(b_req), 0);
      cyc = 1'b0; stb = 1'b0;
      step();

      // Silent slave on u_b write runs into the timeout.
      rst = 1'b1; step(); rst = 1'b0; step();
      we = 1'b1; odat = 16'h5A3C; adr = 24'($urandom);
      cyc = 1'b1; stb = 1'b1;
      step();
      repeat (4) step();
      check("b_w0", 32'(b_io), 32'h3C);
      step();
      check("b_w1", 32'(b_io), 32'h5A);
      t = 0;
      seen = 1'b0;
      do begin
         step();
         t++;
         if (b_ack) seen = 1'b1;
      end while (!b_err && t < 20);
      check("b_to_cyc", 32'(t), 9);
      check("b_to_ack", 32'(seen), 0);
      cyc = 1'b0; stb = 1'b0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cw_bus_master.md
CW_BUS_MASTER -- requirements
Module: cw_bus_master

Interface
REQ-001 Parameter ADDR_W, default 24, Wishbone address width.
REQ-002 Parameter DATA_W, default 16, Wishbone data width.
REQ-003 Parameter SEL_W, default 2, byte-select width.
REQ-004 Parameter CW_W, default 16, CW bus beat width; any value 4..DATA_W SHALL be supported.
REQ-005 Parameter TIMEOUT, default 255, response-wait limit in cycles; 0 disables the timeout.
REQ-006 i_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-007 i_rst  in  1  synchronous, active-high reset.
REQ-008 wb_cyc, wb_stb, wb_we  in  1 each  Wishbone slave request.
REQ-009 wb_adr  in  ADDR_W; wb_o_dat  in  DATA_W; wb_sel  in  SEL_W; wb_4_burst, wb_8_burst  in  1 each.
REQ-010 wb_i_dat  out  DATA_W; wb_ack, wb_err  out  1 each, registered single-cycle pulses.
REQ-011 cw_io_o  out  CW_W, master-driven beat; cw_io_i  in  CW_W, slave-driven beat.
REQ-012 cw_req  out  1, frame active; cw_dir  out  1, 0 = master drives cw_io, 1 = slave drives.
REQ-013 cw_ack, cw_err  in  1 each, slave beat-accept and error strobes.

Function
REQ-014 Header H = {we, burst[1:0], sel, adr}, HDR_W = 3+SEL_W+ADDR_W bits, SHALL be sent in HB = ceil(HDR_W/CW_W) beats, LSB first, zero-padded.
REQ-015 Burst code SHALL be 00 single (1 word), 01 for wb_4_burst (4 words), 10 for wb_8_burst (8 words); wb_8_burst takes priority.
REQ-016 Each data word SHALL take DB = ceil(DATA_W/CW_W) beats, LSB first.
REQ-017 States SHALL be IDLE, HDR, WDATA, WACK, TURN, RDATA, END.
REQ-018 IDLE: on wb_cyc&wb_stb, latch header fields and word count, assert cw_req, go to HDR next cycle.
REQ-019 HDR: one header beat per cycle on cw_io_o with cw_dir=0; after beat HB-1 go to WDATA if we, else TURN.
REQ-020 WDATA: DB beats of the current wb_o_dat, one per cycle, sampled when the first beat is issued; then WACK.
REQ-021 WACK: wait for cw_ack; on it, pulse wb_ack next cycle, then WDATA if words remain, else END.
REQ-022 TURN: one cycle with cw_dir=1 and cw_io_o=0; then RDATA.
REQ-023 RDATA: each cycle with cw_ack=1 captures cw_io_i into the next beat slot; after beat DB-1, present the assembled word on wb_i_dat with a wb_ack pulse in the same cycle; then RDATA for the next word or END.
REQ-024 cw_err in WACK or RDATA SHALL pulse wb_err next cycle, cancel remaining words, and go to END.
REQ-025 A wait-cycle counter SHALL reset on each cw_ack and on entering WACK/RDATA; reaching TIMEOUT (TIMEOUT>0) SHALL act as cw_err.
REQ-026 cw_ack and cw_err together SHALL be treated as cw_err.
REQ-027 END: cw_req=0, cw_dir=0 for exactly one cycle, then IDLE; back-to-back requests therefore have one idle bus cycle.
REQ-028 wb_cyc falling in any non-IDLE state SHALL abort: go to END with no wb_ack or wb_err issued; cw_req falling is the slave-side abort indication.
REQ-029 cw_ack/cw_err outside WACK/RDATA SHALL be ignored.
REQ-030 wb_ack and wb_err SHALL never assert in the same cycle, and SHALL never assert without wb_cyc.

Reset
REQ-031 i_rst SHALL force IDLE, clear counters, and set cw_req=0, cw_dir=0, cw_io_o=0, wb_ack=0, wb_err=0, wb_i_dat=0 on the next edge, including mid-frame.

Verification
REQ-032 Single write, defaults: adr 0x001234, sel 11, data 0xBEEF -> beats 0x1234, 0x1300, 0xBEEF with cw_dir=0; cw_ack -> one wb_ack; END one cycle.
REQ-033 Burst-4 read at adr 0x000100, sel 11 -> beats 0x0100, 0x0700; one TURN cycle; slave acks 0x1111..0x4444 -> four wb_ack pulses carrying those values.
REQ-034 CW_W=8, single read -> 4 header beats; two acked beats 0xCD then 0xAB -> wb_i_dat=0xABCD.
REQ-035 TIMEOUT=8, write, slave silent -> wb_err exactly 8 cycles after entering WACK; no wb_ack.
REQ-036 Burst-8 read, cw_err on word 3 -> wb_ack for words 0-2 only, one wb_err, END; i_rst asserted mid-HDR -> all outputs 0 next cycle.
